// File: rtl/lcd_pkg.sv
// Shared opcodes, decoder state encoding and register-file layout for the LCD SPI sink.
package lcd_pkg;

    localparam logic [7:0] CMD_SLPIN   = 8'h10;
    localparam logic [7:0] CMD_SLPOUT  = 8'h11;
    localparam logic [7:0] CMD_INVOFF  = 8'h20;
    localparam logic [7:0] CMD_INVON   = 8'h21;
    localparam logic [7:0] CMD_DISPOFF = 8'h28;
    localparam logic [7:0] CMD_DISPON  = 8'h29;
    localparam logic [7:0] CMD_CASET   = 8'h2A;
    localparam logic [7:0] CMD_RASET   = 8'h2B;
    localparam logic [7:0] CMD_RAMWR   = 8'h2C;
    localparam logic [7:0] CMD_MADCTL  = 8'h36;
    localparam logic [7:0] CMD_COLMOD  = 8'h3A;
    localparam logic [7:0] COLMOD_RST  = 8'h05;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_PARAM = 2'd1,
        ST_RAMWR = 2'd2,
        ST_SKIP  = 2'd3
    } sink_state_e;

    typedef struct packed {
        sink_state_e state;
        logic [7:0]  pcmd;
        logic [1:0]  pcnt;
        logic [23:0] pbuf;
        logic [15:0] xs, xe, ys, ye, cx, cy;
        logic        phase;
        logic [7:0]  hi;
        logic        cmd_valid;
        logic [7:0]  cmd_byte;
        logic        pix_valid;
        logic [15:0] pix_x, pix_y, pix_data;
        logic [7:0]  madctl, colmod;
        logic        awake, disp_on, inverted;
    } sink_regs_t;

    function automatic sink_regs_t sink_reset(input logic [15:0] xe, input logic [15:0] ye);
        sink_regs_t r;
        r        = '0;
        r.state  = ST_IDLE;
        r.xe     = xe;
        r.ye     = ye;
        r.colmod = COLMOD_RST;
        return r;
    endfunction

endpackage

// File: rtl/lcd_spi_byte_rx.sv
// SPI byte receiver: synchronizes the four LCD pins into clk and assembles MSB-first bytes.
module lcd_spi_byte_rx #(
    parameter int SYNC_STAGES = 2
) (
    input  logic       clk,
    input  logic       resetn,
    input  logic       sck_i,
    input  logic       cs_i,
    input  logic       rs_i,
    input  logic       sda_i,
    output logic       byte_valid,
    output logic [7:0] byte_data,
    output logic       byte_dc
);

    localparam logic [3:0] PINS_IDLE = 4'b0100;

    logic [3:0] sync_q [SYNC_STAGES];
    logic [3:0] pins_s;
    logic       sck_prev_q, rise_q, cs_q, rs_q, sda_q;
    logic [2:0] cnt_q;
    logic [6:0] shift_q;
    logic       byte_valid_q, byte_dc_q;
    logic [7:0] byte_data_q;

    assign pins_s     = sync_q[SYNC_STAGES-1];
    assign byte_valid = byte_valid_q;
    assign byte_data  = byte_data_q;
    assign byte_dc    = byte_dc_q;

    // Synchronizer chain for {sck, cs, rs, sda}.
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            for (int i = 0; i < SYNC_STAGES; i++) sync_q[i] <= PINS_IDLE;
        end else begin
            sync_q[0] <= {sck_i, cs_i, rs_i, sda_i};
            for (int i = 1; i < SYNC_STAGES; i++) sync_q[i] <= sync_q[i-1];
        end
    end

    // Edge detect: an edge is kept if cs was low now or one clk earlier, so a cs release
    // landing on the same clk as the last edge still completes the byte.
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            sck_prev_q <= 1'b0;
            rise_q     <= 1'b0;
            cs_q       <= 1'b1;
            rs_q       <= 1'b0;
            sda_q      <= 1'b0;
        end else begin
            sck_prev_q <= pins_s[3];
            rise_q     <= pins_s[3] & ~sck_prev_q & ~(pins_s[2] & cs_q);
            cs_q       <= pins_s[2];
            rs_q       <= pins_s[1];
            sda_q      <= pins_s[0];
        end
    end

    // Shift register and bit counter; cs high discards a partial byte.
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            cnt_q        <= 3'd0;
            shift_q      <= 7'd0;
            byte_valid_q <= 1'b0;
            byte_data_q  <= 8'd0;
            byte_dc_q    <= 1'b0;
        end else begin
            byte_valid_q <= rise_q && (cnt_q == 3'd7);
            if (rise_q) begin
                cnt_q   <= cnt_q + 3'd1;
                shift_q <= {shift_q[5:0], sda_q};
                if (cnt_q == 3'd7) begin
                    byte_data_q <= {shift_q, sda_q};
                    byte_dc_q   <= rs_q;
                end
            end else if (cs_q) begin
                cnt_q <= 3'd0;
            end
        end
    end

endmodule

// File: rtl/lcd_spi_sink.sv
// Display-side decoder of the ST7789-style LCD SPI stream into register updates and pixel writes.
// Optional sticky error flags are built only when LCD_SINK_ERR_EN is defined.
module lcd_spi_sink
    import lcd_pkg::*;
#(
    parameter int          SYNC_STAGES = 2,
    parameter logic [15:0] DEF_XE      = 16'd239,
    parameter logic [15:0] DEF_YE      = 16'd319
) (
    input  logic        clk,
    input  logic        resetn,
    input  logic        lcd_clk,
    input  logic        lcd_cs,
    input  logic        lcd_rs,
    input  logic        lcd_data,
    output logic        cmd_valid,
    output logic [7:0]  cmd_byte,
    output logic        pix_valid,
    output logic [15:0] pix_x,
    output logic [15:0] pix_y,
    output logic [15:0] pix_data,
    output logic [7:0]  madctl,
    output logic [7:0]  colmod,
    output logic        awake,
    output logic        disp_on,
    output logic        inverted,
    output logic [3:0]  err
);

    logic        byte_valid_s, byte_dc_s;
    logic [7:0]  byte_data_s;
    logic [15:0] win_lo_s, win_hi_s;
    sink_regs_t  r_q, r_d;

    lcd_spi_byte_rx #(.SYNC_STAGES(SYNC_STAGES)) u_rx (
        .clk        (clk),
        .resetn     (resetn),
        .sck_i      (lcd_clk),
        .cs_i       (lcd_cs),
        .rs_i       (lcd_rs),
        .sda_i      (lcd_data),
        .byte_valid (byte_valid_s),
        .byte_data  (byte_data_s),
        .byte_dc    (byte_dc_s)
    );

    assign win_lo_s = r_q.pbuf[23:8];
    assign win_hi_s = {r_q.pbuf[7:0], byte_data_s};

    // Decoder state register.
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            r_q <= sink_reset(DEF_XE, DEF_YE);
        end else begin
            r_q <= r_d;
        end
    end

    // Command decode, parameter collection and RAMWR cursor walk.
    always_comb begin
        r_d           = r_q;
        r_d.cmd_valid = 1'b0;
        r_d.pix_valid = 1'b0;
        if (byte_valid_s && !byte_dc_s) begin
            r_d.cmd_valid = 1'b1;
            r_d.cmd_byte  = byte_data_s;
            r_d.pcmd      = byte_data_s;
            r_d.pcnt      = 2'd0;
            r_d.state     = ST_IDLE;
            case (byte_data_s)
                CMD_CASET, CMD_RASET, CMD_MADCTL, CMD_COLMOD: r_d.state = ST_PARAM;
                CMD_RAMWR: begin
                    r_d.state = ST_RAMWR;
                    r_d.cx    = r_q.xs;
                    r_d.cy    = r_q.ys;
                    r_d.phase = 1'b0;
                end
                CMD_SLPOUT:  r_d.awake    = 1'b1;
                CMD_SLPIN:   r_d.awake    = 1'b0;
                CMD_DISPON:  r_d.disp_on  = 1'b1;
                CMD_DISPOFF: r_d.disp_on  = 1'b0;
                CMD_INVON:   r_d.inverted = 1'b1;
                CMD_INVOFF:  r_d.inverted = 1'b0;
                default:     r_d.state    = ST_SKIP;
            endcase
        end else if (byte_valid_s && (r_q.state == ST_PARAM)) begin
            r_d.pbuf = {r_q.pbuf[15:0], byte_data_s};
            r_d.pcnt = r_q.pcnt + 2'd1;
            case (r_q.pcmd)
                CMD_MADCTL: begin
                    r_d.madctl = byte_data_s;
                    r_d.state  = ST_IDLE;
                end
                CMD_COLMOD: begin
                    r_d.colmod = byte_data_s;
                    r_d.state  = ST_IDLE;
                end
                default: begin
                    if (r_q.pcnt == 2'd3) begin
                        r_d.state = ST_IDLE;
                        if (r_q.pcmd == CMD_CASET) begin
                            r_d.xs = win_lo_s;
                            r_d.xe = win_hi_s;
                        end else begin
                            r_d.ys = win_lo_s;
                            r_d.ye = win_hi_s;
                        end
                    end else begin
                        r_d.state = ST_PARAM;
                    end
                end
            endcase
        end else if (byte_valid_s && (r_q.state == ST_RAMWR)) begin
            r_d.phase = ~r_q.phase;
            if (!r_q.phase) begin
                r_d.hi = byte_data_s;
            end else begin
                r_d.pix_valid = 1'b1;
                r_d.pix_x     = r_q.cx;
                r_d.pix_y     = r_q.cy;
                r_d.pix_data  = {r_q.hi, byte_data_s};
                if (r_q.cx == r_q.xe) begin
                    r_d.cx = r_q.xs;
                    r_d.cy = (r_q.cy == r_q.ye) ? r_q.ys : r_q.cy + 16'd1;
                end else begin
                    r_d.cx = r_q.cx + 16'd1;
                end
            end
        end else begin
            r_d.state = r_q.state;
        end
    end

`ifdef LCD_SINK_ERR_EN
    logic [3:0] err_q, err_set_s;

    // Protocol violations seen on the byte stream.
    always_comb begin
        err_set_s = 4'd0;
        if (byte_valid_s) begin
            err_set_s[0] = byte_dc_s && (r_q.state == ST_IDLE);
            err_set_s[1] = !byte_dc_s && (r_q.state == ST_PARAM);
            err_set_s[2] = byte_dc_s && (r_q.state == ST_PARAM) && (r_q.pcnt == 2'd3) &&
                           ((r_q.pcmd == CMD_CASET) || (r_q.pcmd == CMD_RASET)) &&
                           (win_lo_s > win_hi_s);
            err_set_s[3] = byte_dc_s && (r_q.state == ST_PARAM) &&
                           (r_q.pcmd == CMD_COLMOD) && (byte_data_s != COLMOD_RST);
        end else begin
            err_set_s = 4'd0;
        end
    end

    // Sticky error flags, cleared only by reset.
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            err_q <= 4'd0;
        end else begin
            err_q <= err_q | err_set_s;
        end
    end

    assign err = err_q;
`else
    assign err = 4'd0;
`endif

    assign cmd_valid = r_q.cmd_valid;
    assign cmd_byte  = r_q.cmd_byte;
    assign pix_valid = r_q.pix_valid;
    assign pix_x     = r_q.pix_x;
    assign pix_y     = r_q.pix_y;
    assign pix_data  = r_q.pix_data;
    assign madctl    = r_q.madctl;
    assign colmod    = r_q.colmod;
    assign awake     = r_q.awake;
    assign disp_on   = r_q.disp_on;
    assign inverted  = r_q.inverted;

endmodule

// File: tb/tb_lcd_spi_sink.sv
// Randomized self-checking bench for lcd_spi_sink against a byte-level reference model.
`timescale 1ns/1ps
module tb_lcd_spi_sink;

    localparam int SS = 2;
    localparam int M_IDLE = 0, M_PARAM = 1, M_RAMWR = 2, M_SKIP = 3;

    logic        clk = 1'b0;
    logic        resetn, lcd_clk, lcd_cs, lcd_rs, lcd_data;
    logic        cmd_valid, pix_valid, awake, disp_on, inverted;
    logic [7:0]  cmd_byte, madctl, colmod;
    logic [15:0] pix_x, pix_y, pix_data;
    logic [3:0]  err;

    int n_checks = 0;
    int n_errors = 0;
    int cyc = 0;
    int last_edge = 0;
    bit lat_armed = 1'b0;
    logic [15:0] obs_x, obs_y, obs_d;
    logic [7:0]  e_cmd;
    logic [47:0] e_pix;
    logic [7:0]  cmd_exp_q[$];
    logic [47:0] pix_exp_q[$];

    int         m_mode, m_need, m_pc, m_nbytes, m_xs, m_xe, m_ys, m_ye;
    logic [7:0] m_pcmd, m_hi, m_madctl, m_colmod;
    logic [7:0] m_pb[4];
    logic       m_awake, m_disp, m_inv;
    logic [3:0] m_err;

    lcd_spi_sink #(.SYNC_STAGES(SS), .DEF_XE(16'd239), .DEF_YE(16'd319)) dut (
        .clk(clk), .resetn(resetn), .lcd_clk(lcd_clk), .lcd_cs(lcd_cs), .lcd_rs(lcd_rs),
        .lcd_data(lcd_data), .cmd_valid(cmd_valid), .cmd_byte(cmd_byte), .pix_valid(pix_valid),
        .pix_x(pix_x), .pix_y(pix_y), .pix_data(pix_data), .madctl(madctl), .colmod(colmod),
        .awake(awake), .disp_on(disp_on), .inverted(inverted), .err(err)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    initial begin
        #1500000;
        $display("FAIL watchdog: simulation did not finish, got no end expected end");
        $fatal(1, "watchdog");
    end

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    function automatic logic [3:0] exp_err();
`ifdef LCD_SINK_ERR_EN
        return m_err;
`else
        return 4'd0;
`endif
    endfunction

    task automatic model_reset();
        m_mode = M_IDLE; m_need = 0; m_pc = 0; m_nbytes = 0;
        m_xs = 0; m_xe = 239; m_ys = 0; m_ye = 319;
        m_pcmd = 8'h00; m_hi = 8'h00; m_madctl = 8'h00; m_colmod = 8'h05;
        m_awake = 1'b0; m_disp = 1'b0; m_inv = 1'b0; m_err = 4'd0;
    endtask

    task automatic model_byte(input logic dc, input logic [7:0] b);
        int s, e, k, w, h;
        if (!dc) begin
            cmd_exp_q.push_back(b);
            if (m_mode == M_PARAM) m_err[1] = 1'b1;
            m_pc = 0; m_pcmd = b; m_mode = M_IDLE;
            case (b)
                8'h2A, 8'h2B: begin m_mode = M_PARAM; m_need = 4; end
                8'h36, 8'h3A: begin m_mode = M_PARAM; m_need = 1; end
                8'h2C: begin m_mode = M_RAMWR; m_nbytes = 0; end
                8'h11: m_awake = 1'b1;
                8'h10: m_awake = 1'b0;
                8'h29: m_disp = 1'b1;
                8'h28: m_disp = 1'b0;
                8'h21: m_inv = 1'b1;
                8'h20: m_inv = 1'b0;
                default: m_mode = M_SKIP;
            endcase
        end else begin
            case (m_mode)
                M_IDLE: m_err[0] = 1'b1;
                M_PARAM: begin
                    m_pb[m_pc] = b;
                    m_pc++;
                    if (m_pc == m_need) begin
                        m_mode = M_IDLE;
                        s = m_pb[0] * 256 + m_pb[1];
                        e = m_pb[2] * 256 + m_pb[3];
                        if (m_pcmd == 8'h36) m_madctl = m_pb[0];
                        else if (m_pcmd == 8'h3A) begin
                            m_colmod = m_pb[0];
                            if (m_pb[0] != 8'h05) m_err[3] = 1'b1;
                        end else begin
                            if (s > e) m_err[2] = 1'b1;
                            if (m_pcmd == 8'h2A) begin m_xs = s; m_xe = e; end
                            else begin m_ys = s; m_ye = e; end
                        end
                    end
                end
                M_RAMWR: begin
                    if (m_nbytes % 2 == 0) m_hi = b;
                    else begin
                        k = m_nbytes / 2;
                        w = m_xe - m_xs + 1;
                        h = m_ye - m_ys + 1;
                        pix_exp_q.push_back({16'(m_xs + k % w), 16'(m_ys + (k / w) % h), m_hi, b});
                    end
                    m_nbytes++;
                end
                default: ;
            endcase
        end
    endtask

    // Every cycle: each cmd/pix strobe must match the next expected model event.
    always @(negedge clk) begin
        if (cmd_valid) begin
            if (cmd_exp_q.size() == 0) check("cmd_unexpected", {56'd0, cmd_byte}, 64'hFFFF_FFFF);
            else begin
                e_cmd = cmd_exp_q.pop_front();
                check("cmd_byte", {56'd0, cmd_byte}, {56'd0, e_cmd});
            end
            if (lat_armed) begin
                check("cmd_latency", 64'(cyc - last_edge), 64'(SS + 3));
                lat_armed = 1'b0;
            end
        end
        if (pix_valid) begin
            obs_x = pix_x; obs_y = pix_y; obs_d = pix_data;
            if (pix_exp_q.size() == 0) check("pix_unexpected", {16'd0, pix_x, pix_y, pix_data}, 64'hFFFF_FFFF);
            else begin
                e_pix = pix_exp_q.pop_front();
                check("pix", {16'd0, pix_x, pix_y, pix_data}, {16'd0, e_pix});
            end
        end
    end

    task automatic send_bits(input logic dc, input logic [7:0] b, input int nbits);
        lcd_cs = 1'b0;
        lcd_rs = dc;
        for (int i = 7; i >= 8 - nbits; i--) begin
            lcd_data = b[i];
            @(negedge clk); @(negedge clk);
            lcd_clk = 1'b1;
            last_edge = cyc;
            @(negedge clk); @(negedge clk);
            lcd_clk = 1'b0;
        end
    endtask

    task automatic send_byte(input logic dc, input logic [7:0] b);
        send_bits(dc, b, 8);
        model_byte(dc, b);
    endtask

    task automatic cs_gap();
        lcd_cs = 1'b1;
        repeat (4) @(negedge clk);
    endtask

    task automatic send_win(input logic [7:0] op, input int s, input int e);
        send_byte(1'b0, op);
        send_byte(1'b1, 8'(s >> 8)); send_byte(1'b1, 8'(s));
        send_byte(1'b1, 8'(e >> 8)); send_byte(1'b1, 8'(e));
    endtask

    task automatic send_pix(input logic [15:0] d);
        send_byte(1'b1, d[15:8]);
        send_byte(1'b1, d[7:0]);
    endtask

    task automatic drain();
        for (int i = 0; i < 40 && (cmd_exp_q.size() != 0 || pix_exp_q.size() != 0); i++)
            @(negedge clk);
        check("drain_pending", 64'(cmd_exp_q.size() + pix_exp_q.size()), 64'd0);
    endtask

    task automatic check_regs();
        check("madctl", {56'd0, madctl}, {56'd0, m_madctl});
        check("colmod", {56'd0, colmod}, {56'd0, m_colmod});
        check("flags", {61'd0, awake, disp_on, inverted}, {61'd0, m_awake, m_disp, m_inv});
        check("err", {60'd0, err}, {60'd0, exp_err()});
    endtask

    task automatic check_reset_outputs();
        check("rst_strobes", {62'd0, cmd_valid, pix_valid}, 64'd0);
        check("rst_pix", {16'd0, pix_x, pix_y, pix_data}, 64'd0);
        check("rst_regs", {32'd0, cmd_byte, madctl, colmod, 5'd0, awake, disp_on, inverted},
              {32'd0, 8'h00, 8'h00, 8'h05, 8'h00});
        check("rst_err", {60'd0, err}, 64'd0);
    endtask

    logic [7:0] ops [10] = '{8'h11, 8'h10, 8'h29, 8'h28, 8'h21, 8'h20, 8'h36, 8'h3A, 8'hB0, 8'h04};

    initial begin
        logic [7:0] op;
        int xs, ys;
        resetn = 1'b0; lcd_clk = 1'b0; lcd_cs = 1'b1; lcd_rs = 1'b0; lcd_data = 1'b0;
        model_reset();
        repeat (3) @(negedge clk);
        check_reset_outputs();
        resetn = 1'b1;
        repeat (3) @(negedge clk);

        // 1: wake-up sequence, first command also checks strobe latency
        lat_armed = 1'b1;
        send_byte(1'b0, 8'h11);
        repeat (10) @(negedge clk);
        send_byte(1'b0, 8'h3A); send_byte(1'b1, 8'h05);
        send_byte(1'b0, 8'h29);
        drain();
        check_regs();
        check("t1_lit", {60'd0, awake, disp_on, colmod == 8'h05, err == 4'd0}, 64'hF);

        // 2: one pixel in window 40..279 x 53..187
        send_win(8'h2A, 16'h0028, 16'h0117);
        send_win(8'h2B, 16'h0035, 16'h00BB);
        send_byte(1'b0, 8'h2C);
        send_pix(16'hF800);
        drain();
        check("t2_lit", {16'd0, obs_x, obs_y, obs_d}, {16'd0, 16'd40, 16'd53, 16'hF800});

        // 3: row wrap over a full row, then frame wrap on a small window
        send_byte(1'b0, 8'h2C);
        for (int i = 0; i < 240; i++) send_pix(16'(i * 37));
        drain();
        check("t3_row_end", {32'd0, obs_x, obs_y}, {32'd0, 16'd279, 16'd53});
        send_pix(16'h1234);
        drain();
        check("t3_row_next", {32'd0, obs_x, obs_y}, {32'd0, 16'd40, 16'd54});
        send_win(8'h2A, 2, 5);
        send_win(8'h2B, 7, 9);
        send_byte(1'b0, 8'h2C);
        for (int i = 0; i < 12; i++) send_pix(16'(i));
        drain();
        check("t3_frame_last", {32'd0, obs_x, obs_y}, {32'd0, 16'd5, 16'd9});
        send_pix(16'hABCD);
        drain();
        check("t3_frame_wrap", {32'd0, obs_x, obs_y}, {32'd0, 16'd2, 16'd7});

        // 4: short CASET aborted by RAMWR leaves the window alone
        send_win(8'h2A, 16'h0028, 16'h0117);
        send_win(8'h2B, 16'h0035, 16'h00BB);
        send_byte(1'b0, 8'h2A); send_byte(1'b1, 8'h00); send_byte(1'b1, 8'h10);
        send_byte(1'b0, 8'h2C);
        send_pix(16'h07E0);
        drain();
        check("t4_lit", {32'd0, obs_x, obs_y}, {32'd0, 16'd40, 16'd53});
        check_regs();
`ifdef LCD_SINK_ERR_EN
        check("t4_err1", {63'd0, err[1]}, 64'd1);
`endif

        // 5: partial byte discarded by cs; pixel split across a cs toggle
        send_bits(1'b0, 8'hFF, 5);
        cs_gap();
        send_win(8'h2A, 16'h0028, 16'h0117);
        send_byte(1'b0, 8'h2C);
        send_byte(1'b1, 8'h12);
        cs_gap();
        send_byte(1'b1, 8'h34);
        drain();
        check("t5_lit", {16'd0, obs_x, obs_y, obs_d}, {16'd0, 16'd40, 16'd53, 16'h1234});

        // random traffic
        for (int it = 0; it < 120; it++) begin
            case ($urandom_range(0, 9))
                0: begin
                    xs = $urandom_range(0, 20); ys = $urandom_range(0, 20);
                    send_win(8'h2A, xs, xs + $urandom_range(0, 5));
                    send_win(8'h2B, ys, ys + $urandom_range(0, 4));
                    send_byte(1'b0, 8'h2C);
                end
                1, 2, 3, 4, 5: begin
                    send_byte(1'b1, 8'($urandom));
                    if ($urandom_range(0, 3) == 0) cs_gap();
                    send_byte(1'b1, 8'($urandom));
                end
                6: begin
                    op = ops[$urandom_range(0, 9)];
                    send_byte(1'b0, op);
                    if (op == 8'h36) send_byte(1'b1, 8'($urandom));
                    if (op == 8'h3A) send_byte(1'b1, ($urandom_range(0, 1) == 0) ? 8'h05 : 8'($urandom));
                end
                7: begin
                    send_bits(1'($urandom), 8'($urandom), $urandom_range(1, 7));
                    cs_gap();
                end
                8: send_byte(1'b1, 8'($urandom));
                default: send_byte(1'b0, 8'h2C);
            endcase
            if ($urandom_range(0, 5) == 0) cs_gap();
        end
        drain();
        check_regs();

        // 6: reset mid-RAMWR, then a data byte in IDLE
        send_byte(1'b0, 8'h2C);
        send_pix(16'h5555);
        send_byte(1'b1, 8'hAA);
        drain();
        resetn = 1'b0;
        lcd_cs = 1'b1;
        @(negedge clk);
        check_reset_outputs();
        model_reset();
        repeat (2) @(negedge clk);
        resetn = 1'b1;
        repeat (3) @(negedge clk);
        send_byte(1'b1, 8'h55);
        repeat (10) @(negedge clk);
        drain();
        check_regs();
`ifdef LCD_SINK_ERR_EN
        check("t6_err0", {63'd0, err[0]}, 64'd1);
`else
        check("t6_err0", {60'd0, err}, 64'd0);
`endif

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule
